pipe_ctrl: RTL

//  Central pipeline controller for the 5-stage (IF/ID/EX/MEM/WB) successor of the single-cycle proc.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_ctrl_haz_unit.sv | 54 +++++
 rtl/pipe_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared types and constants for the 5-stage pipeline controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  // Bit positions inside stage_valid
  localparam int STAGE_ID  = 0;
  localparam int STAGE_EX  = 1;
  localparam int STAGE_MEM = 2;
  localparam int STAGE_WB  = 3;

  localparam logic [15:0] EXC_VECTOR = 16'h0004;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_haz_unit.sv
// ============================================================================
// Module : haz_unit
// Brief  : Combinational RAW hazard detector between ID sources and the
//          in-flight writers in EX/MEM/WB.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module haz_unit #(
  parameter int FWD  = 1,
  parameter int RA_W = 3
) (
  input  logic            v_id,
  input  logic [RA_W-1:0] dec_rs,
  input  logic            dec_rs_rd,
  input  logic [RA_W-1:0] dec_rt,
  input  logic            dec_rt_rd,
  input  logic            v_ex,
  input  logic            v_mem,
  input  logic            v_wb,
  input  logic [RA_W-1:0] ex_rd,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            ex_wr,
  input  logic            mem_wr,
  input  logic            wb_wr,
  input  logic            ex_memrd,
  output logic            haz
);

  function automatic logic writer_hit(input logic v, input logic wr,
                                      input logic [RA_W-1:0] rd,
                                      input logic [RA_W-1:0] r);
    return v & wr & (rd == r);
  endfunction

  function automatic logic src_match(input logic [RA_W-1:0] r);
    logic w_load_use;
    logic w_any_writer;
    w_load_use   = ex_memrd & writer_hit(v_ex, ex_wr, ex_rd, r);
    w_any_writer = writer_hit(v_ex, ex_wr, ex_rd, r)
                 | writer_hit(v_mem, mem_wr, mem_rd, r)
                 | writer_hit(v_wb, wb_wr, wb_rd, r);
    // With forwarding only a load in EX cannot deliver its result in time
    return (FWD != 0) ? w_load_use : w_any_writer;
  endfunction

  always_comb begin
    haz = v_id & ((dec_rs_rd & src_match(dec_rs)) | (dec_rt_rd & src_match(dec_rt)));
  end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module : pipe_ctrl
// Brief  : Pipeline controller: stage valids, stalls, flushes, EPC capture,
//          halt drain and stall counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int RA_W  = 3,
  parameter int FWD   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  dec_rs,
  input  logic             dec_rs_rd,
  input  logic [RA_W-1:0]  dec_rt,
  input  logic             dec_rt_rd,
  input  logic             dec_halt,
  input  logic             dec_exc,
  input  logic [PC_W-1:0]  exc_pc,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic             ex_wr,
  input  logic             mem_wr,
  input  logic             wb_wr,
  input  logic             ex_memrd,
  input  logic             redirect,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pc_sel_vec,
  output logic [3:0]       stage_valid,
  output logic [PC_W-1:0]  epc,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             err
);

  state_e            state_q, state_d;
  logic              v_id_q, v_id_d, v_ex_q, v_ex_d;
  logic              v_mem_q, v_mem_d, v_wb_q, v_wb_d;
  logic [PC_W-1:0]   epc_q, epc_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              err_q, err_d, halted_q, halted_d;
  logic              w_haz, w_redir, w_exc, w_strobe;

  haz_unit #(.FWD(FWD), .RA_W(RA_W)) u_haz (
    .v_id      (v_id_q),
    .dec_rs    (dec_rs),
    .dec_rs_rd (dec_rs_rd),
    .dec_rt    (dec_rt),
    .dec_rt_rd (dec_rt_rd),
    .v_ex      (v_ex_q),
    .v_mem     (v_mem_q),
    .v_wb      (v_wb_q),
    .ex_rd     (ex_rd),
    .mem_rd    (mem_rd),
    .wb_rd     (wb_rd),
    .ex_wr     (ex_wr),
    .mem_wr    (mem_wr),
    .wb_wr     (wb_wr),
    .ex_memrd  (ex_memrd),
    .haz       (w_haz)
  );

  always_comb begin
    w_redir     = redirect & v_ex_q;
    w_exc       = dec_exc & v_id_q;
    w_strobe    = dec_rs_rd | dec_rt_rd | dec_halt | dec_exc;
    state_d     = state_q;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pc_sel_vec  = 1'b0;
    epc_d       = epc_q;
    stall_cnt_d = stall_cnt_q;
    err_d       = err_q | (redirect & ~v_ex_q);

    case (state_q)
      RUN: begin
        if (w_redir) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (w_exc) begin
          epc_d      = exc_pc;
          pc_sel_vec = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (w_haz) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
        end else if (dec_halt & v_id_q) begin
          state_d    = DRAIN;
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          ifid_flush = 1'b1;
        end
      end
      DRAIN: begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
      end
      HALTED: begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        if (w_strobe) err_d = 1'b1;
      end
      default: begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        err_d   = 1'b1;
        state_d = HALTED;
      end
    endcase

    v_wb_d  = v_mem_q;
    v_mem_d = v_ex_q;
    v_ex_d  = v_id_q & ~idex_flush;
    v_id_d  = ifid_flush ? 1'b0 : (ifid_we ? (state_q == RUN) : v_id_q);
    if (state_q != RUN) v_id_d = 1'b0;

    // Enter HALTED on the edge that empties the back end, so halted and the
    // all-clear valids appear together
    if (state_q == DRAIN && !(v_ex_d | v_mem_d | v_wb_d)) state_d = HALTED;
    if (state_q != RUN && state_q != DRAIN) begin
      v_ex_d  = 1'b0;
      v_mem_d = 1'b0;
      v_wb_d  = 1'b0;
    end
    halted_d = (state_d == HALTED);

    stage_valid            = '0;
    stage_valid[STAGE_ID]  = v_id_q;
    stage_valid[STAGE_EX]  = v_ex_q;
    stage_valid[STAGE_MEM] = v_mem_q;
    stage_valid[STAGE_WB]  = v_wb_q;
    epc                    = epc_q;
    stall_cnt              = stall_cnt_q;
    err                    = err_q;
    halted                 = halted_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      v_id_q      <= 1'b0;
      v_ex_q      <= 1'b0;
      v_mem_q     <= 1'b0;
      v_wb_q      <= 1'b0;
      epc_q       <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_id_q      <= v_id_d;
      v_ex_q      <= v_ex_d;
      v_mem_q     <= v_mem_d;
      v_wb_q      <= v_wb_d;
      epc_q       <= epc_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
      halted_q    <= halted_d;
    end
  end

endmodule

`default_nettype wire
